// File: rtl/iir_biquad_cascade_pkg.sv
// Shared types and arithmetic rules for the time-shared biquad cascade.
// The round/saturate helpers work on a 64-bit signed carrier so any ACCW <= 64 fits.
package iir_biquad_cascade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int TAP_B0 = 0;
  localparam int TAP_B1 = 1;
  localparam int TAP_B2 = 2;
  localparam int TAP_A1 = 3;
  localparam int TAP_A2 = 4;
  localparam int NCOEF  = 5;

  // Round half up, then arithmetic shift by frac bits.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_mac.sv
// Shared signed multiply-accumulate plus the round-shift-saturate stage.
// y reflects acc + current term, so the caller can take it on the last tap.
module iir_mac_sat
  import iir_biquad_cascade_pkg::*;
#(
  parameter int DW   = 18,
  parameter int CW   = 18,
  parameter int FRAC = 16,
  parameter int ACCW = DW + CW + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_clr,
  input  logic                 acc_en,
  input  logic                 sub,
  input  logic signed [CW-1:0] coef,
  input  logic signed [DW-1:0] data,
  output logic signed [DW-1:0] y
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_q;
  logic signed [63:0]     shaped;

  always_comb begin
    prod   = PW'(coef) * PW'(data);
    term   = sub ? -(ACCW'(prod)) : ACCW'(prod);
    sum    = acc_q + term;
    shaped = sat_val(round_shift(64'(sum), FRAC), DW);
    y      = DW'(shaped);
    acc_d  = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC direct-form-I biquads sharing one MAC, five taps per section.
// Coefficients live in a writable bank; delay lines are per-section arrays.
module iir_biquad_cascade
  import iir_biquad_cascade_pkg::*;
#(
  parameter int DW     = 18,
  parameter int CW     = 18,
  parameter int FRAC   = 16,
  parameter int NSEC   = 3,
  parameter int ACCW   = DW + CW + 4,
  parameter int B0_DEF = 50586,
  parameter int B1_DEF = -99759,
  parameter int B2_DEF = 50586,
  parameter int A1_DEF = -113135,
  parameter int A2_DEF = 55149
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 coef_we,
  input  logic [5:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic [1:0]           dbg_state
);

  // Handshake: a sample is taken on a rising edge where din_valid && din_ready;
  // din_ready is high only in IDLE, dout_valid pulses for one cycle with dout.
  localparam int NC = NCOEF * NSEC;

  state_e               state_q, state_d;
  logic [2:0]           sec_q, sec_d;
  logic [2:0]           tap_q, tap_d;
  logic signed [DW-1:0] xcur_q, xcur_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 din_ready_q, din_ready_d;
  logic signed [DW-1:0] x1_q[NSEC], x1_d[NSEC];
  logic signed [DW-1:0] x2_q[NSEC], x2_d[NSEC];
  logic signed [DW-1:0] y1_q[NSEC], y1_d[NSEC];
  logic signed [DW-1:0] y2_q[NSEC], y2_d[NSEC];
  logic signed [CW-1:0] coef_q[NC], coef_d[NC];

  logic [5:0]           cidx;
  logic signed [CW-1:0] coef_sel;
  logic signed [DW-1:0] data_sel;
  logic signed [DW-1:0] y_sec;
  logic                 last_tap;
  logic                 mac_en;
  logic                 mac_clr;
  logic                 mac_sub;

  always_comb begin
    cidx     = 6'(sec_q) * 6'd5 + 6'(tap_q);
    coef_sel = '0;
    for (int i = 0; i < NC; i++) begin
      if (cidx == 6'(i)) coef_sel = coef_q[i];
    end
    data_sel = xcur_q;
    for (int s = 0; s < NSEC; s++) begin
      if (sec_q == 3'(s)) begin
        case (tap_q)
          3'(TAP_B1): data_sel = x1_q[s];
          3'(TAP_B2): data_sel = x2_q[s];
          3'(TAP_A1): data_sel = y1_q[s];
          3'(TAP_A2): data_sel = y2_q[s];
          default:    data_sel = xcur_q;
        endcase
      end
    end
    last_tap = (tap_q == 3'(TAP_A2));
    // Feedback taps are subtracted so the stored a1/a2 keep their natural sign.
    mac_sub  = (tap_q == 3'(TAP_A1)) || last_tap;
    mac_en   = (state_q == MAC) && !clr;
    mac_clr  = clr || (mac_en && last_tap);
  end

  iir_mac_sat #(
    .DW  (DW),
    .CW  (CW),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .acc_clr(mac_clr),
    .acc_en (mac_en),
    .sub    (mac_sub),
    .coef   (coef_sel),
    .data   (data_sel),
    .y      (y_sec)
  );

  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    tap_d        = tap_q;
    xcur_d       = xcur_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    coef_d       = coef_q;

    if (clr) begin
      state_d = IDLE;
      sec_d   = '0;
      tap_d   = '0;
      for (int s = 0; s < NSEC; s++) begin
        x1_d[s] = '0;
        x2_d[s] = '0;
        y1_d[s] = '0;
        y2_d[s] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            xcur_d  = din;
            sec_d   = '0;
            tap_d   = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          if (last_tap) begin
            for (int s = 0; s < NSEC; s++) begin
              if (sec_q == 3'(s)) begin
                x2_d[s] = x1_q[s];
                x1_d[s] = xcur_q;
                y2_d[s] = y1_q[s];
                y1_d[s] = y_sec;
              end
            end
            xcur_d = y_sec;
            tap_d  = '0;
            if (sec_q == 3'(NSEC - 1)) begin
              dout_d       = y_sec;
              dout_valid_d = 1'b1;
              sec_d        = '0;
              state_d      = OUT;
            end else begin
              sec_d = sec_q + 3'd1;
            end
          end else begin
            tap_d = tap_q + 3'd1;
          end
        end
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Addresses beyond the bank match no entry and are dropped.
    if (state_q == IDLE && coef_we) begin
      for (int i = 0; i < NC; i++) begin
        if (coef_addr == 6'(i)) coef_d[i] = coef_wdata;
      end
    end

    din_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      tap_q        <= '0;
      xcur_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
      for (int s = 0; s < NSEC; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
      for (int i = 0; i < NC; i++) begin
        case (i % NCOEF)
          TAP_B0:  coef_q[i] <= CW'(B0_DEF);
          TAP_B1:  coef_q[i] <= CW'(B1_DEF);
          TAP_B2:  coef_q[i] <= CW'(B2_DEF);
          TAP_A1:  coef_q[i] <= CW'(A1_DEF);
          default: coef_q[i] <= CW'(A2_DEF);
        endcase
      end
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      tap_q        <= tap_d;
      xcur_q       <= xcur_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      coef_q       <= coef_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for the biquad cascade: one NSEC=1 and one NSEC=3 instance.
module tb_iir_biquad_cascade;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic signed [17:0] din1 = '0, din3 = '0;
  logic               dv1 = 1'b0, dv3 = 1'b0;
  logic               rdy1, rdy3, ov1, ov3;
  logic signed [17:0] dout1, dout3;
  logic               we1 = 1'b0, we3 = 1'b0;
  logic [5:0]         addr1 = '0, addr3 = '0;
  logic signed [17:0] wd1 = '0, wd3 = '0;
  logic [1:0]         st1, st3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iir_biquad_cascade #(.NSEC(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .dout(dout1), .dout_valid(ov1), .coef_we(we1), .coef_addr(addr1),
    .coef_wdata(wd1), .dbg_state(st1)
  );

  iir_biquad_cascade #(.NSEC(3)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .din(din3), .din_valid(dv3), .din_ready(rdy3),
    .dout(dout3), .dout_valid(ov3), .coef_we(we3), .coef_addr(addr3),
    .coef_wdata(wd3), .dbg_state(st3)
  );

  typedef struct {
    logic signed [17:0] din;
    logic signed [17:0] exp_y;
    int                 exp_lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_sample(input int k, input logic signed [17:0] x, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < 200 && !((k == 1) ? rdy1 : rdy3)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL start_timeout: din_ready never rose on instance %0d", k);
    end else begin
      if (k == 1) begin din1 = x; dv1 = 1'b1; end
      else begin din3 = x; dv3 = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      dv1 = 1'b0;
      dv3 = 1'b0;
      din1 = 18'($urandom_range(0, 262143));
      din3 = 18'($urandom_range(0, 262143));
      ok = 1'b1;
    end
  endtask

  task automatic finish_sample(input int k, output logic signed [17:0] y,
                               output int lat, output int low, output int nval);
    int e;
    logic r, v;
    e = 0; y = '0; lat = 0; low = 0; nval = 0;
    while (e < 100) begin
      r = (k == 1) ? rdy1 : rdy3;
      v = (k == 1) ? ov1 : ov3;
      if (v) begin
        nval++;
        if (lat == 0) lat = e + 1;
        y = (k == 1) ? dout1 : dout3;
      end
      if (r) break;
      low++;
      @(negedge clk);
      e++;
    end
    if (e >= 100) begin
      n_checks++;
      $display("FAIL result_timeout: no return to ready on instance %0d", k);
    end
  endtask

  task automatic run_sample(input int k, input logic signed [17:0] x,
                            output logic signed [17:0] y, output int lat,
                            output int low, output int nval);
    bit ok;
    start_sample(k, x, ok);
    if (ok) finish_sample(k, y, lat, low, nval);
    else begin y = '0; lat = 0; low = 0; nval = 0; end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic write_coef(input logic [5:0] a, input logic signed [17:0] d);
    we1 = 1'b1; addr1 = a; wd1 = d;
    @(negedge clk);
    we1 = 1'b0;
  endtask

  initial begin
    vec_t tv[3];
    logic signed [17:0] y;
    int lat, low, nval, cnt;
    bit ok;

    tv[0] = '{din: 18'sd65536, exp_y: 18'sd50586,  exp_lat: 6};
    tv[1] = '{din: 18'sd0,     exp_y: -18'sd12432, exp_lat: 6};
    tv[2] = '{din: 18'sd0,     exp_y: -18'sd13444, exp_lat: 6};

    // clock/reset
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dout1", dout1, 0);
    check("rst_valid1", ov1, 0);
    check("rst_ready1", rdy1, 1);
    check("rst_dout3", dout3, 0);
    check("rst_valid3", ov3, 0);
    check("rst_ready3", rdy3, 1);

    // Impulse through NSEC=1 with default coefficients
    for (int i = 0; i < 3; i++) begin
      run_sample(1, tv[i].din, y, lat, low, nval);
      check($sformatf("imp1_y[%0d]", i), y, tv[i].exp_y);
      check($sformatf("imp1_lat[%0d]", i), lat, tv[i].exp_lat);
      check($sformatf("imp1_low[%0d]", i), low, 6);
      check($sformatf("imp1_npulse[%0d]", i), nval, 1);
    end

    // Zero input through NSEC=3
    for (int i = 0; i < 20; i++) begin
      run_sample(3, 18'sd0, y, lat, low, nval);
      check($sformatf("zero3_y[%0d]", i), y, 0);
      check($sformatf("zero3_low[%0d]", i), low, 16);
    end
    run_sample(3, 18'sd65536, y, lat, low, nval);
    check("imp3_y", y, 30139);
    check("imp3_lat", lat, 16);

    // clr four cycles after an accept edge aborts the sample
    start_sample(1, 18'sd65536, ok);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ready_next", rdy1, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov1) cnt++;
      @(negedge clk);
    end
    check("clr_no_valid", cnt, 0);
    check("clr_dout_held", dout1, -13444);
    run_sample(1, 18'sd65536, y, lat, low, nval);
    check("clr_imp_y0", y, 50586);
    run_sample(1, 18'sd0, y, lat, low, nval);
    check("clr_imp_y1", y, -12432);

    // Coefficient write while busy is ignored; in IDLE it applies
    pulse_clr();
    start_sample(1, 18'sd65536, ok);
    write_coef(6'd0, 18'sd0);
    finish_sample(1, y, lat, low, nval);
    check("busy_we_ignored", y, 50586);
    pulse_clr();
    write_coef(6'd0, 18'sd0);
    run_sample(1, 18'sd65536, y, lat, low, nval);
    check("idle_we_b0_zero", y, 0);

    // Saturation at both rails; addr 5 is outside the NSEC=1 bank
    write_coef(6'd0, 18'sd131071);
    for (int a = 1; a < 5; a++) write_coef(6'(a), 18'sd0);
    write_coef(6'd5, 18'sd0);
    pulse_clr();
    run_sample(1, 18'sd131071, y, lat, low, nval);
    check("sat_hi", y, 131071);
    run_sample(1, -18'sd131072, y, lat, low, nval);
    check("sat_lo", y, -131072);

    // Reset mid-computation on both instances
    start_sample(3, 18'sd65536, ok);
    start_sample(1, 18'sd65536, ok);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_dout1", dout1, 0);
    check("rstmid_valid1", ov1, 0);
    check("rstmid_ready1", rdy1, 1);
    check("rstmid_dout3", dout3, 0);
    check("rstmid_valid3", ov3, 0);
    check("rstmid_ready3", rdy3, 1);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov1 || ov3) cnt++;
      @(negedge clk);
    end
    check("rstmid_no_valid", cnt, 0);
    run_sample(1, 18'sd65536, y, lat, low, nval);
    check("rstmid_coef_default", y, 50586);
    check("rstmid_lat", lat, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
